// File: rtl/reg_wrapper_if.sv
// Operand-pair bus for reg_wrapper: the serial word stream into the
// capture register and the registered (A, B) pair with its load strobe.
//   data_in  : operand word stream, one word per clock
//   reg_a    : first operand of the most recently completed pair
//   reg_b    : second operand of the most recently completed pair
//   write_en : one-cycle strobe, pair just loaded
interface reg_wrapper_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic             write_en;

    // Source of words / consumer of pairs (e.g. the upstream/downstream side).
    modport master (
        output data_in,
        input  reg_a,
        input  reg_b,
        input  write_en
    );

    // The capture register itself.
    modport slave (
        input  data_in,
        output reg_a,
        output reg_b,
        output write_en
    );
endinterface

// File: rtl/reg_wrapper.sv
// Operand-pair capture register: groups a serial stream of words into
// (A, B) pairs and presents each pair coherently with a one-cycle strobe.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : reg_wrapper_if.slave (data_in in; reg_a, reg_b, write_en out)
module reg_wrapper #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    reg_wrapper_if.slave  bus
);

    typedef enum logic {
        LOAD_A = 1'b0,
        LOAD_B = 1'b1
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] hold_a_q;
    logic [WIDTH-1:0] hold_a_d;
    logic [WIDTH-1:0] reg_a_q;
    logic [WIDTH-1:0] reg_a_d;
    logic [WIDTH-1:0] reg_b_q;
    logic [WIDTH-1:0] reg_b_d;
    logic             write_en_q;
    logic             write_en_d;

    // Every non-reset edge consumes one word; A is parked in hold_a
    // so that reg_a and reg_b can be loaded together on the B edge.
    always_comb begin
        state_d    = state_q;
        hold_a_d   = hold_a_q;
        reg_a_d    = reg_a_q;
        reg_b_d    = reg_b_q;
        write_en_d = 1'b0;
        unique case (state_q)
            LOAD_A: begin
                hold_a_d = bus.data_in;
                state_d  = LOAD_B;
            end
            LOAD_B: begin
                reg_a_d    = hold_a_q;
                reg_b_d    = bus.data_in;
                write_en_d = 1'b1;
                state_d    = LOAD_A;
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    // Reset wins over a completing pair and discards any parked A word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD_A;
            hold_a_q   <= '0;
            reg_a_q    <= '0;
            reg_b_q    <= '0;
            write_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_a_q   <= hold_a_d;
            reg_a_q    <= reg_a_d;
            reg_b_q    <= reg_b_d;
            write_en_q <= write_en_d;
        end
    end

    assign bus.reg_a    = reg_a_q;
    assign bus.reg_b    = reg_b_q;
    assign bus.write_en = write_en_q;

endmodule

// File: tb/tb_reg_wrapper.sv
// Testbench for reg_wrapper: directed word stream with hand-computed
// expected pairs, checked by a decoupled scoreboard monitor.
module tb_reg_wrapper;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    reg_wrapper_if #(.WIDTH(16)) bus ();

    reg_wrapper #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic [15:0] a;
        logic [15:0] b;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   drv_done = 1'b0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one word (and reset level) for the next edge; queue the
    // output state required after that edge.
    task automatic step(input logic r, input logic [15:0] din,
                        input logic [15:0] ea, input logic [15:0] eb, input logic ewe);
        exp_t e;
        @(negedge clk);
        rst         = r;
        bus.data_in = din;
        e.rst = r;
        e.a   = ea;
        e.b   = eb;
        e.we  = ewe;
        sb.push_back(e);
    endtask

    // Monitor: after each edge compare outputs with the oldest expectation
    // and check pair coherence against the previous cycle.
    initial begin
        exp_t        e;
        logic [15:0] pa;
        logic [15:0] pb;
        logic        pwe;
        bit          have_prev;
        have_prev = 1'b0;
        pa = '0;
        pb = '0;
        pwe = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("reg_a", bus.reg_a, e.a);
                chk("reg_b", bus.reg_b, e.b);
                chk("write_en", {15'd0, bus.write_en}, {15'd0, e.we});
                chk("no_1111_a", {15'd0, bus.reg_a == 16'h1111}, 16'd0);
                chk("no_1111_b", {15'd0, bus.reg_b == 16'h1111}, 16'd0);
                if (have_prev) begin
                    if (bus.reg_a !== pa || bus.reg_b !== pb)
                        chk("load_needs_we_or_rst",
                            {15'd0, bus.write_en | e.rst}, 16'd1);
                    chk("we_not_back_to_back",
                        {15'd0, bus.write_en & pwe}, 16'd0);
                end
                pa = bus.reg_a;
                pb = bus.reg_b;
                pwe = bus.write_en;
                have_prev = 1'b1;
            end
        end
    end

    initial begin
        int budget;
        bus.data_in = 16'h0000;
        // reset held for 3 edges
        step(1'b1, 16'hAAAA, 16'h0000, 16'h0000, 1'b0);
        step(1'b1, 16'h5555, 16'h0000, 16'h0000, 1'b0);
        step(1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
        // basic pair
        step(1'b0, 16'hBEA3, 16'h0000, 16'h0000, 1'b0);
        step(1'b0, 16'h4073, 16'hBEA3, 16'h4073, 1'b1);
        // stream of subnormals
        step(1'b0, 16'h000C, 16'hBEA3, 16'h4073, 1'b0);
        step(1'b0, 16'h000D, 16'h000C, 16'h000D, 1'b1);
        step(1'b0, 16'h000E, 16'h000C, 16'h000D, 1'b0);
        step(1'b0, 16'h000F, 16'h000E, 16'h000F, 1'b1);
        step(1'b0, 16'h0010, 16'h000E, 16'h000F, 1'b0);
        step(1'b0, 16'h0011, 16'h0010, 16'h0011, 1'b1);
        // reset mid-pair
        step(1'b0, 16'h1111, 16'h0010, 16'h0011, 1'b0);
        step(1'b1, 16'h9999, 16'h0000, 16'h0000, 1'b0);
        step(1'b0, 16'h2222, 16'h0000, 16'h0000, 1'b0);
        step(1'b0, 16'h3333, 16'h2222, 16'h3333, 1'b1);
        // reset on the completing edge
        step(1'b0, 16'h4444, 16'h2222, 16'h3333, 1'b0);
        step(1'b1, 16'h5555, 16'h0000, 16'h0000, 1'b0);
        // recovery, NaN passes bit-exact
        step(1'b0, 16'h6666, 16'h0000, 16'h0000, 1'b0);
        step(1'b0, 16'h7777, 16'h6666, 16'h7777, 1'b1);
        step(1'b0, 16'h8888, 16'h6666, 16'h7777, 1'b0);
        step(1'b0, 16'h7E01, 16'h8888, 16'h7E01, 1'b1);
        step(1'b0, 16'hFC00, 16'h8888, 16'h7E01, 1'b0);
        drv_done = 1'b1;
        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
